// File: rtl/tx_frame_arbiter_pkg.sv
// Shared TX-domain definitions for the frame arbiter:
// state encoding, default timing constants and counter widths.
package tx_frame_arbiter_pkg;

    localparam int IFG_DEFAULT           = 12;
    localparam int START_TIMEOUT_DEFAULT = 64;
    localparam int FRAME_COUNT_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_SENDING   = 3'd3,
        ST_GAP       = 3'd4
    } tx_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. Returns one-hot grant, its index and a valid flag.
module tx_frame_arbiter_rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            pos = sum[IW-1:0];
            if (!valid && req[pos]) begin
                valid      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter sharing the byte-level Ethernet transmitter among
// frame sources, with inter-frame gap and busy-response watchdog.
module tx_frame_arbiter
    import tx_frame_arbiter_pkg::*;
#(
    parameter  int NREQ          = 2,
    parameter  int IFG_CYCLES    = IFG_DEFAULT,
    parameter  int START_TIMEOUT = START_TIMEOUT_DEFAULT,
    localparam int SW            = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW            = $clog2(max_int(IFG_CYCLES, START_TIMEOUT) + 1)
) (
    input  logic                     clk125MHz,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req,
    input  logic                     pause,
    input  logic                     busy,
    output logic [NREQ-1:0]          ack,
    output logic [SW-1:0]            sel,
    output logic                     start_sending,
    output logic                     active,
    output logic                     timeout_err,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    tx_state_e       state_q;
    tx_state_e       state_d;
    logic [CW-1:0]   cnt_q;
    logic [SW-1:0]   rr_ptr_q;
    logic [NREQ-1:0] pick_grant;
    logic [SW-1:0]   pick_idx;
    logic            pick_valid;
    logic            grant_now;
    logic            wd_expire;
    logic            gap_done;
    logic            counting;

    tx_frame_arbiter_rr_pick #(
        .N (NREQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign grant_now = (state_q == ST_IDLE) && !pause && !busy
                       && pick_valid;
    assign wd_expire = (state_q == ST_WAIT_BUSY) && !busy
                       && (cnt_q == CW'(START_TIMEOUT - 1));
    assign gap_done  = (state_q == ST_GAP)
                       && (cnt_q == CW'(IFG_CYCLES - 1));
    assign counting  = (state_q == ST_WAIT_BUSY) || (state_q == ST_GAP);

    // Fires in the last allowed WAIT_BUSY cycle; a late busy still wins.
    assign timeout_err = wd_expire;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_now) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (busy) begin
                    state_d = ST_SENDING;
                end else if (wd_expire) begin
                    state_d = ST_GAP;
                end
            end
            ST_SENDING: begin
                if (!busy) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk125MHz or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rr_ptr_q      <= '0;
            ack           <= '0;
            sel           <= '0;
            start_sending <= 1'b0;
            active        <= 1'b0;
            frame_count   <= '0;
        end else begin
            state_q       <= state_d;
            start_sending <= grant_now;
            ack           <= grant_now ? pick_grant : '0;
            active        <= (state_d != ST_IDLE);

            // Shared counter restarts on every state entry.
            if ((state_d != state_q) || !counting) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (grant_now) begin
                sel <= pick_idx;
            end

            if (state_q == ST_START) begin
                if (sel == SW'(NREQ - 1)) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= sel + 1'b1;
                end
            end

            if ((state_q == ST_WAIT_BUSY) && busy) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed self-checking bench for tx_frame_arbiter (NREQ=2, IFG=12,
// START_TIMEOUT=64); inputs and samples are taken on the falling edge.
module tb_tx_frame_arbiter;

    logic        clk125MHz = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req = 2'b00;
    logic        pause = 1'b0;
    logic        busy = 1'b0;
    logic [1:0]  ack;
    logic [0:0]  sel;
    logic        start_sending;
    logic        active;
    logic        timeout_err;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;
    int exp_fc = 0;
    bit ok;

    tx_frame_arbiter #(
        .NREQ          (2),
        .IFG_CYCLES    (12),
        .START_TIMEOUT (64)
    ) dut (
        .clk125MHz     (clk125MHz),
        .RST           (RST),
        .req           (req),
        .pause         (pause),
        .busy          (busy),
        .ack           (ack),
        .sel           (sel),
        .start_sending (start_sending),
        .active        (active),
        .timeout_err   (timeout_err),
        .frame_count   (frame_count)
    );

    always #4 clk125MHz = ~clk125MHz;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk125MHz);
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (start_sending !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        chk({tag, "_start"}, 32'(start_sending), 32'd1);
    endtask

    task automatic run_frame(input int exp_sel, input string tag);
        logic [1:0] exp_ack;
        bit         stable;
        exp_ack = 2'b01 << exp_sel;
        wait_start(tag);
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        tick(2);
        busy = 1'b1;
        tick();
        exp_fc++;
        chk({tag, "_fc"}, 32'(frame_count), 32'(exp_fc));
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (sel !== 1'(exp_sel)) stable = 1'b0;
        end
        chk({tag, "_sel_stable"}, 32'(stable), 32'd1);
        busy = 1'b0;
        tick();
    endtask

    initial begin
        // Reset values
        tick(2);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_start", 32'(start_sending), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        RST = 1'b0;
        tick();
        chk("idle_active", 32'(active), 32'd0);

        // Single request, one-cycle grant latency
        req = 2'b01;
        tick();
        chk("single_start", 32'(start_sending), 32'd1);
        chk("single_ack", 32'(ack), 32'd1);
        chk("single_sel", 32'(sel), 32'd0);
        chk("single_active", 32'(active), 32'd1);
        req = 2'b00;
        tick();
        chk("single_start_pulse", 32'(start_sending), 32'd0);
        chk("single_ack_pulse", 32'(ack), 32'd0);
        tick(2);
        busy = 1'b1;
        tick();
        exp_fc = 1;
        chk("single_fc", 32'(frame_count), 32'(exp_fc));
        ok = 1'b1;
        repeat (99) begin
            tick();
            if (ack !== 2'b00 || start_sending !== 1'b0 || sel !== 1'b0
                || active !== 1'b1) ok = 1'b0;
        end
        chk("single_sending_quiet", 32'(ok), 32'd1);

        // Minimum gap: next start 14 clocks after busy falls
        busy = 1'b0;
        req = 2'b01;
        ok = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (start_sending !== 1'b0) ok = 1'b0;
            if (k == 12) chk("gap_active_end", 32'(active), 32'd1);
            if (k == 13) chk("gap_idle", 32'(active), 32'd0);
        end
        chk("gap_no_early_start", 32'(ok), 32'd1);
        tick();
        chk("gap_start_14", 32'(start_sending), 32'd1);
        chk("gap_sel", 32'(sel), 32'd0);

        // Watchdog: busy never rises
        req = 2'b00;
        tick();
        ok = 1'b1;
        if (timeout_err !== 1'b0) ok = 1'b0;
        repeat (62) begin
            tick();
            if (timeout_err !== 1'b0) ok = 1'b0;
        end
        chk("wd_quiet_63", 32'(ok), 32'd1);
        tick();
        chk("wd_fire_64", 32'(timeout_err), 32'd1);
        tick();
        chk("wd_pulse_end", 32'(timeout_err), 32'd0);
        chk("wd_gap_active", 32'(active), 32'd1);
        chk("wd_fc", 32'(frame_count), 32'(exp_fc));
        tick(11);
        chk("wd_gap_last", 32'(active), 32'd1);
        tick();
        chk("wd_idle", 32'(active), 32'd0);

        // Asynchronous reset in the middle of SENDING
        req = 2'b01;
        wait_start("rstmid");
        req = 2'b00;
        tick(2);
        busy = 1'b1;
        tick();
        exp_fc++;
        chk("rstmid_fc", 32'(frame_count), 32'(exp_fc));
        tick(3);
        #2 RST = 1'b1;
        #1;
        chk("rstmid_ack", 32'(ack), 32'd0);
        chk("rstmid_start", 32'(start_sending), 32'd0);
        chk("rstmid_active", 32'(active), 32'd0);
        chk("rstmid_fc0", 32'(frame_count), 32'd0);
        chk("rstmid_sel", 32'(sel), 32'd0);
        exp_fc = 0;
        tick();
        busy = 1'b0;
        req = 2'b11;
        tick();
        RST = 1'b0;

        // Contention: pointer restarts at 0, strict alternation
        run_frame(0, "cont0");
        run_frame(1, "cont1");
        run_frame(0, "cont2");
        run_frame(1, "cont3");
        run_frame(0, "cont4");
        run_frame(1, "cont5");
        req = 2'b00;
        chk("cont_fc", 32'(frame_count), 32'd6);
        tick(14);

        // Pause mid-frame: frame completes, no grant while paused
        req = 2'b01;
        wait_start("pause");
        chk("pause_sel", 32'(sel), 32'd0);
        tick(2);
        busy = 1'b1;
        tick();
        exp_fc++;
        pause = 1'b1;
        tick(5);
        busy = 1'b0;
        ok = 1'b1;
        repeat (40) begin
            tick();
            if (ack !== 2'b00 || start_sending !== 1'b0) ok = 1'b0;
        end
        chk("pause_no_grant", 32'(ok), 32'd1);
        chk("pause_fc", 32'(frame_count), 32'(exp_fc));
        chk("pause_idle", 32'(active), 32'd0);
        pause = 1'b0;
        tick();
        chk("pause_release_start", 32'(start_sending), 32'd1);
        chk("pause_release_ack", 32'(ack), 32'd1);
        req = 2'b00;
        tick(2);
        busy = 1'b1;
        tick();
        exp_fc++;
        busy = 1'b0;
        chk("pause_fc2", 32'(frame_count), 32'(exp_fc));
        tick(16);

        // Counter wrap from 0xFFFF
        force dut.frame_count = 16'hFFFF;
        tick();
        release dut.frame_count;
        tick();
        chk("wrap_preload", 32'(frame_count), 32'h0000FFFF);
        req = 2'b01;
        wait_start("wrap");
        req = 2'b00;
        tick();
        busy = 1'b1;
        tick();
        chk("wrap_fc", 32'(frame_count), 32'd0);
        busy = 1'b0;
        tick(16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
